// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame defaults and line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        s_IDLE  = 3'b000,
        s_START = 3'b001,
        s_DATA  = 3'b010,
        s_STOP  = 3'b011
    } uart_state_e;

    localparam int unsigned DATA_BITS_DEF = 8;
    localparam logic        LINE_IDLE     = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchronizer for asynchronous UART inputs; resets to the idle line level
// so that no false edge is seen when reset is released.
module uart_sync
    import uart_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{LINE_IDLE}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit near mid-period
// using the run-time clk_div bit period, and presents bytes with one-cycle strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           clk_div,
    input  logic                 Rx_Serial,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Valid,
    output logic                 Rx_Err,
    output logic                 Rx_Active
);

    localparam int unsigned IDXW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [3:0]           count_q;
    logic [IDXW-1:0]      bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 err_q;
    logic                 active_q;
    logic                 s_prev_q;

    logic                 s;
    logic [3:0]           count_d;
    logic [3:0]           half;
    logic [3:0]           last;
    logic [DATA_BITS-1:0] shift_d;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (Rx_Serial),
        .q_o (s)
    );

    assign count_d = count_q + 4'd1;
    assign half    = {1'b0, clk_div[3:1]};
    assign last    = clk_div - 4'd1;
    // Right shift so the first received (LSB) bit ends up in bit 0.
    assign shift_d = {s, shift_q[DATA_BITS-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= s_IDLE;
            count_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            active_q  <= 1'b0;
            s_prev_q  <= LINE_IDLE;
        end else begin
            s_prev_q <= s;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                s_IDLE: begin
                    active_q <= 1'b0;
                    count_q  <= '0;
                    if (s_prev_q && !s && (clk_div >= 4'd2)) begin
                        state_q  <= s_START;
                        active_q <= 1'b1;
                    end
                end
                s_START: begin
                    count_q <= count_d;
                    if (count_q == half) begin
                        if (s) begin
                            state_q  <= s_IDLE;
                            active_q <= 1'b0;
                            count_q  <= '0;
                        end else begin
                            state_q   <= s_DATA;
                            count_q   <= '0;
                            bit_idx_q <= '0;
                        end
                    end
                end
                s_DATA: begin
                    count_q <= count_d;
                    if (count_q == last) begin
                        shift_q <= shift_d;
                        count_q <= '0;
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= s_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDXW'(1);
                        end
                    end
                end
                s_STOP: begin
                    count_q <= count_d;
                    if (count_q == last) begin
                        if (s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q  <= s_IDLE;
                        active_q <= 1'b0;
                        count_q  <= '0;
                    end
                end
                default: begin
                    state_q  <= s_IDLE;
                    active_q <= 1'b0;
                    count_q  <= '0;
                end
            endcase
        end
    end

    assign Rx_Data   = data_q;
    assign Rx_Valid  = valid_q;
    assign Rx_Err    = err_q;
    assign Rx_Active = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: drives 8N1 frames on Rx_Serial and checks received
// bytes, strobe timing, false starts, framing errors, reset and illegal clk_div.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic [3:0] clk_div;
    logic       Rx_Serial;
    logic [7:0] Rx_Data;
    logic       Rx_Valid;
    logic       Rx_Err;
    logic       Rx_Active;

    uart_rx #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_div   (clk_div),
        .Rx_Serial (Rx_Serial),
        .Rx_Data   (Rx_Data),
        .Rx_Valid  (Rx_Valid),
        .Rx_Err    (Rx_Err),
        .Rx_Active (Rx_Active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after posedge N, cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor sampled mid-cycle, away from the active edge.
    int         vcnt = 0;
    int         ecnt = 0;
    int         act_cnt = 0;
    int         both_cnt = 0;
    int         last_eedge = 0;
    logic [7:0] vdata [0:31];
    int         vedge [0:31];

    always @(negedge clk) begin
        if (Rx_Valid) begin
            vdata[vcnt % 32] = Rx_Data;
            vedge[vcnt % 32] = cyc;
            vcnt = vcnt + 1;
        end
        if (Rx_Err) begin
            ecnt       = ecnt + 1;
            last_eedge = cyc;
        end
        if (Rx_Active) act_cnt = act_cnt + 1;
        if (Rx_Valid && Rx_Err) both_cnt = both_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Callers are always aligned to #1 after a posedge.
    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line bit j is sampled at edges k+j*bit_len ... ; extra lengthens the start bit.
    task automatic send_frame(input logic [7:0] data, input int unsigned bit_len,
                              input int unsigned extra, input logic stop_v,
                              output int k);
        Rx_Serial = 1'b0;
        k = cyc + 1;
        idle(bit_len + extra);
        for (int i = 0; i < 8; i++) begin
            Rx_Serial = data[i];
            idle(bit_len);
        end
        Rx_Serial = stop_v;
        idle(bit_len);
    endtask

    int k;
    int v0, e0, a0;

    initial begin
        rst       = 1'b0;
        Rx_Serial = 1'b1;
        clk_div   = 4'd10;
        @(posedge clk);
        @(negedge clk);
        check("reset_data",   Rx_Data,   8'h00);
        check("reset_valid",  Rx_Valid,  1'b0);
        check("reset_err",    Rx_Err,    1'b0);
        check("reset_active", Rx_Active, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(5);

        // Clean frame at clk_div=10: strobe after edge k+3+5+90.
        v0 = vcnt; e0 = ecnt; a0 = act_cnt;
        send_frame(8'hA5, 10, 0, 1'b1, k);
        idle(5);
        check("a5_vcount", vcnt - v0, 1);
        check("a5_data",   vdata[v0 % 32], 8'hA5);
        check("a5_vedge",  vedge[v0 % 32], k + 98);
        check("a5_err",    ecnt - e0, 0);
        check("a5_active_seen", (act_cnt > a0), 1'b1);
        check("a5_active_end",  Rx_Active, 1'b0);
        check("a5_data_hold",   Rx_Data, 8'hA5);

        // Three-clock low glitch is rejected at the start-bit sample.
        v0 = vcnt; e0 = ecnt;
        Rx_Serial = 1'b0;
        idle(3);
        Rx_Serial = 1'b1;
        idle(30);
        check("glitch_vcount", vcnt - v0, 0);
        check("glitch_err",    ecnt - e0, 0);
        check("glitch_data",   Rx_Data, 8'hA5);
        check("glitch_active", Rx_Active, 1'b0);

        // Framing error followed by a held-low line (break).
        v0 = vcnt; e0 = ecnt;
        send_frame(8'h3C, 10, 0, 1'b0, k);
        idle(40);
        check("ferr_ecount", ecnt - e0, 1);
        check("ferr_eedge",  last_eedge, k + 98);
        check("ferr_vcount", vcnt - v0, 0);
        check("ferr_data",   Rx_Data, 8'hA5);
        Rx_Serial = 1'b1;
        idle(20);
        check("break_ecount", ecnt - e0, 1);
        check("break_vcount", vcnt - v0, 0);
        check("break_active", Rx_Active, 1'b0);
        send_frame(8'h5A, 10, 0, 1'b1, k);
        idle(5);
        check("rearm_vcount", vcnt - v0, 1);
        check("rearm_data",   Rx_Data, 8'h5A);

        // Back-to-back frames, one stop bit each. At clk_div=2 the sample point sits
        // one clock after mid-bit, so the start bit is stretched by one clock.
        clk_div = 4'd2;
        idle(3);
        v0 = vcnt; e0 = ecnt;
        send_frame(8'h00, 2, 1, 1'b1, k);
        send_frame(8'hFF, 2, 1, 1'b1, k);
        idle(6);
        check("b2b2_vcount", vcnt - v0, 2);
        check("b2b2_first",  vdata[v0 % 32], 8'h00);
        check("b2b2_second", vdata[(v0 + 1) % 32], 8'hFF);
        check("b2b2_err",    ecnt - e0, 0);

        clk_div = 4'd15;
        idle(3);
        v0 = vcnt; e0 = ecnt;
        send_frame(8'h00, 15, 0, 1'b1, k);
        send_frame(8'hFF, 15, 0, 1'b1, k);
        idle(10);
        check("b2b15_vcount", vcnt - v0, 2);
        check("b2b15_first",  vdata[v0 % 32], 8'h00);
        check("b2b15_second", vdata[(v0 + 1) % 32], 8'hFF);
        check("b2b15_err",    ecnt - e0, 0);
        check("b2b15_last",   vedge[(v0 + 1) % 32], k + 3 + 7 + 135);

        // Reset during data bit 4, then a clean frame.
        clk_div = 4'd10;
        idle(3);
        v0 = vcnt; e0 = ecnt;
        Rx_Serial = 1'b0;
        idle(10);
        for (int i = 0; i < 4; i++) begin
            Rx_Serial = i[0] ? 1'b0 : 1'b1;
            idle(10);
        end
        Rx_Serial = 1'b1;
        idle(5);
        check("rstmid_active_before", Rx_Active, 1'b1);
        rst = 1'b0;
        #1;
        check("rstmid_data",   Rx_Data,   8'h00);
        check("rstmid_valid",  Rx_Valid,  1'b0);
        check("rstmid_err",    Rx_Err,    1'b0);
        check("rstmid_active", Rx_Active, 1'b0);
        idle(3);
        rst = 1'b1;
        idle(20);
        check("rstmid_nopulse", (vcnt - v0) + (ecnt - e0), 0);
        send_frame(8'h81, 10, 0, 1'b1, k);
        idle(5);
        check("post_rst_vcount", vcnt - v0, 1);
        check("post_rst_data",   Rx_Data, 8'h81);

        // Illegal clk_div values: line activity is ignored.
        for (int d = 0; d < 2; d++) begin
            clk_div = 4'(d);
            idle(3);
            v0 = vcnt; e0 = ecnt; a0 = act_cnt;
            send_frame(8'h55, 10, 0, 1'b1, k);
            idle(20);
            check("divlow_active", act_cnt - a0, 0);
            check("divlow_pulses", (vcnt - v0) + (ecnt - e0), 0);
        end
        check("divlow_data_hold", Rx_Data, 8'h81);

        check("never_both", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
